nebula_l2_arbiter: RTL

Shares the cluster's single line-wide L2 memory port (`mem_req`/`mem_ack`, 512-bit lines, 56-bit physical address) between several requesters, for example the cluster data path and a future instruction-fetch path, ahead of the AXI adapter. It applies round-robin arbitration and holds the grant for one whole transaction. All outputs toward memory are registered, and responses are returned as a one-cycle registered ack pulse. It sits between the requesters and the adapter's `dmem_*` port.

---
 rtl/nebula_l2_arb_pkg.sv | 6 +
 rtl/nebula_rr_picker.sv | 20 ++
 rtl/nebula_l2_arbiter.sv | 95 +++++++++
 3 files changed

// File: rtl/nebula_l2_arb_pkg.sv
// nebula_l2_arb_pkg: shared state encoding and default widths for the L2 port arbiter.
package nebula_l2_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} l2arb_state_e;
    localparam int L2_PADDR_WIDTH = 56;
    localparam int L2_LINE_WIDTH  = 512;
endpackage

// File: rtl/nebula_rr_picker.sv
// nebula_rr_picker: combinational round-robin pick of the lowest requester at or after ptr.
module nebula_rr_picker #(
    parameter int NUM_REQ = 2,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               any_req
);
    always_comb begin
        idx = '0;
        any_req = |req;
        // Walk offsets from farthest to nearest so the nearest set bit is written last.
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req[(int'(ptr) + i) % NUM_REQ]) idx = IW'((int'(ptr) + i) % NUM_REQ);
        grant = {NUM_REQ{any_req}} & (NUM_REQ'(1) << idx);
    end
endmodule

// File: rtl/nebula_l2_arbiter.sv
// nebula_l2_arbiter: round-robin sharing of the single L2 line port, one transaction per grant.
// Optional ISSUE watchdog compiled in with NEBULA_L2ARB_TIMEOUT_EN.
module nebula_l2_arbiter
    import nebula_l2_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int PADDR_WIDTH    = L2_PADDR_WIDTH,
    parameter int LINE_WIDTH     = L2_LINE_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*PADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*LINE_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             req_ack,
    output logic [NUM_REQ-1:0]             req_error,
    output logic [LINE_WIDTH-1:0]          req_rdata,
    output logic                           mem_req,
    output logic                           mem_we,
    output logic [PADDR_WIDTH-1:0]         mem_addr,
    output logic [LINE_WIDTH-1:0]          mem_wdata,
    input  logic                           mem_ack,
    input  logic [LINE_WIDTH-1:0]          mem_rdata,
    input  logic                           mem_error,
    output logic                           busy,
    output logic [IW-1:0]                  grant_id
);
    l2arb_state_e       state;
    logic [IW-1:0]      rr_ptr, pick_idx;
    logic [NUM_REQ-1:0] pick_grant, gnt_q;
    logic               any_req, timeout;

    nebula_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req(req_valid), .ptr(rr_ptr), .grant(pick_grant), .idx(pick_idx), .any_req(any_req)
    );

`ifdef NEBULA_L2ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else cnt <= (state == ISSUE) ? cnt + 1'b1 : '0;
    assign timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
`else
    assign timeout = TIMEOUT_CYCLES < 0;
`endif

    assign busy = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            gnt_q     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            req_ack   <= '0;
            req_error <= '0;
            req_rdata <= '0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    mem_req   <= 1'b1;
                    mem_we    <= req_we[pick_idx];
                    mem_addr  <= req_addr[pick_idx*PADDR_WIDTH +: PADDR_WIDTH];
                    mem_wdata <= req_wdata[pick_idx*LINE_WIDTH +: LINE_WIDTH];
                    grant_id  <= pick_idx;
                    gnt_q     <= pick_grant;
                    state     <= ISSUE;
                end
                // A real ack takes priority over a watchdog expiry in the same cycle.
                ISSUE: if (mem_ack || timeout) begin
                    mem_req   <= 1'b0;
                    req_ack   <= gnt_q;
                    req_error <= gnt_q & {NUM_REQ{!mem_ack || mem_error}};
                    req_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
                    rr_ptr    <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    req_ack   <= '0;
                    req_error <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
